pipe_regfile: RTL and testbench
===============================

# pipe_regfile

Parametrised successor to the 16-bit, 8-entry, 2-read-port register file used by the ID stage. It provides a configurable register array with:
- N combinational read ports.
- One synchronous write port, driven from WB.
- Write-to-read bypass in the same cycle.
- An optional hardwired-zero register 0.
- A per-register pending-write scoreboard. ID sets entries on issue and WB clears them on writeback; ID uses the result to stall on RAW hazards.

## Interface
Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports.
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and is never pending.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  read data for port i (combinational).
- rd_busy  output  NUM_RD  port i's register has an outstanding write (combinational).
- wr_en  input  1  WB write strobe.
- wr_addr  input  ADDR_W  WB destination register.
- wr_data  input  DATA_W  WB write data.
- issue_en  input  1  ID issues an instruction that will write issue_addr.
- issue_addr  input  ADDR_W  destination of the issued instruction.
- flush  input  1  clear every pending bit (branch/jump squash); data array untouched.
- issue_err  output  1  registered one-cycle pulse: an issue targeted an already-pending register.

## Operation
- State:
  - array mem[DEPTH] of DATA_W bits.
  - pending vector of DEPTH bits.
  - issue_err flop.
- Reset: on a rising edge with rst_n = 0:
  - every mem entry is cleared to 0.
  - pending is cleared to all zeros.
  - issue_err is cleared to 0.
  - All other inputs are ignored that cycle.
- Write: on a rising edge with wr_en = 1, mem[wr_addr] <= wr_data. With ZERO_REG = 1 and wr_addr = 0, no write occurs.
- Read port i, evaluated in this priority order:
  1. ZERO_REG = 1 and rd_addr_i = 0 → rd_data_i = 0.
  2. wr_en = 1 and wr_addr = rd_addr_i → rd_data_i = wr_data (bypass).
  3. Otherwise rd_data_i = mem[rd_addr_i].
- Busy port i: rd_busy_i = pending[rd_addr_i], forced to 0 in either of these cases:
  - a same-cycle write to rd_addr_i (wr_en = 1, wr_addr = rd_addr_i);
  - ZERO_REG = 1 and rd_addr_i = 0.
- Scoreboard next-state, per register r, evaluated in this priority order:
  1. rst_n = 0 → 0.
  2. flush = 1 → 0. Flush also discards a same-cycle issue_en.
  3. issue_en = 1 and issue_addr = r → 1. Issue beats a same-cycle writeback to the same register, because the new producer is younger.
  4. wr_en = 1 and wr_addr = r → 0.
  5. Otherwise hold.
- Register 0 with ZERO_REG = 1: pending[0] is held at 0 and issue_en to address 0 sets nothing.
- issue_err:
  - Next value = issue_en & ~flush & pending[issue_addr] & ~(wr_en & wr_addr = issue_addr), with rst_n = 1.
  - It is cleared by reset.
  - The pending bit stays set; only one outstanding write per register is supported.
- Writes to a non-pending register are legal (e.g. after a flush). They update mem and leave pending unchanged.

## Timing
- Read latency: 0 cycles, combinational from rd_addr, wr_en, wr_addr, wr_data and state.
- Write latency: data is visible through mem on the cycle after the write edge, and through the bypass in the same cycle.
- Scoreboard:
  - An issue at edge k makes rd_busy high from cycle k+1.
  - A writeback in cycle k drops rd_busy combinationally in cycle k and clears the bit at edge k.
- issue_err: asserted the cycle after the offending issue, for exactly one cycle.
- Reset mid-operation: a reset edge overrides any coincident write, issue or flush. In the following cycle:
  - all rd_data = 0 unless bypassed;
  - all rd_busy = 0;
  - issue_err = 0.
- All read ports are independent. Identical addresses on several ports return identical data and busy values.

## Test plan
- Reset then read: hold rst_n = 0 for 1 edge, release, read all 8 addresses on both ports → every rd_data = 0x0000, every rd_busy = 0, issue_err = 0.
- Write/bypass: wr_en = 1, wr_addr = 5, wr_data = 0xBEEF, rd_addr0 = 5 in the same cycle → rd_data0 = 0xBEEF that cycle. After the edge, with wr_en = 0 → rd_data0 = 0xBEEF from mem.
- Scoreboard: issue_en, issue_addr = 3 at edge 1 → rd_busy for address 3 is 1 in cycles 2–3. wr_en, wr_addr = 3, wr_data = 0x1234 in cycle 4 → rd_busy = 0 and rd_data = 0x1234 in cycle 4, and pending[3] = 0 from cycle 5.
- Simultaneous issue and writeback on reg 2 (pending) → pending[2] stays 1 and issue_err stays 0. A second issue to reg 2 without writeback → issue_err = 1 for exactly one cycle.
- Flush: set pending on regs 1, 4 and 6, then pulse flush together with issue_en to reg 7 → all rd_busy = 0 the next cycle and pending[7] = 0.
- ZERO_REG = 1, DATA_W = 32, NUM_RD = 3: write 0xFFFFFFFF to reg 0 and issue to reg 0 → every port reading 0 returns 0 with rd_busy = 0, before and after the edge.

Source files
------------

// File: rtl/pipe_regfile.sv
// rtl/pipe_regfile.sv - parametrised register file with WB bypass and pending-write scoreboard
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   rd_addr    in   NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    out  NUM_RD packed read data, combinational
//   rd_busy    out  per-port outstanding-write flag, combinational
//   wr_en      in   WB write strobe
//   wr_addr    in   WB destination register
//   wr_data    in   WB write data
//   issue_en   in   ID issues an instruction that writes issue_addr
//   issue_addr in   destination of the issued instruction
//   flush      in   clear every pending bit, data untouched
//   issue_err  out  registered pulse: issue hit an already-pending register

module pipe_regfile #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic                     issue_err
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;
  logic              issue_err_next;
  logic              wr_blocked;

  // Writes to the hardwired zero register are dropped.
  assign wr_blocked = ZERO_EN && (wr_addr == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else if (wr_en && !wr_blocked) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Issue is applied after writeback so a younger producer wins the same register.
  always_comb begin
    pending_next = pending;
    if (flush) begin
      pending_next = '0;
    end else begin
      if (wr_en) begin
        pending_next[wr_addr] = 1'b0;
      end
      if (issue_en) begin
        pending_next[issue_addr] = 1'b1;
      end
    end
    if (ZERO_EN) begin
      pending_next[0] = 1'b0;
    end
  end

  // A writeback landing on the same register this cycle retires the old producer,
  // so re-issuing to it is not a double booking.
  always_comb begin
    issue_err_next = issue_en && !flush && pending[issue_addr] &&
                     !(wr_en && (wr_addr == issue_addr));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      issue_err <= 1'b0;
    end else begin
      pending   <= pending_next;
      issue_err <= issue_err_next;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              zero_hit;
    logic              wr_hit;

    assign addr     = rd_addr[i*ADDR_W +: ADDR_W];
    assign zero_hit = ZERO_EN && (addr == '0);
    assign wr_hit   = wr_en && (wr_addr == addr);

    assign rd_data[i*DATA_W +: DATA_W] = zero_hit ? '0 :
                                         wr_hit   ? wr_data :
                                                    mem[addr];
    assign rd_busy[i] = pending[addr] && !zero_hit && !wr_hit;
  end

endmodule

// File: tb/tb_pipe_regfile.sv
// tb/tb_pipe_regfile.sv - directed self-checking bench for pipe_regfile

module tb_pipe_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: 16-bit, 8 entries, 2 read ports, no zero register.
  logic        a_rst_n;
  logic [5:0]  a_rd_addr;
  logic [31:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en;
  logic [2:0]  a_wr_addr;
  logic [15:0] a_wr_data;
  logic        a_issue_en;
  logic [2:0]  a_issue_addr;
  logic        a_flush;
  logic        a_issue_err;

  // Zero-register configuration: 32-bit, 3 read ports.
  logic        b_rst_n;
  logic [8:0]  b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_wr_en;
  logic [2:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_issue_en;
  logic [2:0]  b_issue_addr;
  logic        b_flush;
  logic        b_issue_err;

  pipe_regfile dut_a (
    .clk        (clk),
    .rst_n      (a_rst_n),
    .rd_addr    (a_rd_addr),
    .rd_data    (a_rd_data),
    .rd_busy    (a_rd_busy),
    .wr_en      (a_wr_en),
    .wr_addr    (a_wr_addr),
    .wr_data    (a_wr_data),
    .issue_en   (a_issue_en),
    .issue_addr (a_issue_addr),
    .flush      (a_flush),
    .issue_err  (a_issue_err)
  );

  pipe_regfile #(
    .DATA_W   (32),
    .ADDR_W   (3),
    .NUM_RD   (3),
    .ZERO_REG (1)
  ) dut_b (
    .clk        (clk),
    .rst_n      (b_rst_n),
    .rd_addr    (b_rd_addr),
    .rd_data    (b_rd_data),
    .rd_busy    (b_rd_busy),
    .wr_en      (b_wr_en),
    .wr_addr    (b_wr_addr),
    .wr_data    (b_wr_data),
    .issue_en   (b_issue_en),
    .issue_addr (b_issue_addr),
    .flush      (b_flush),
    .issue_err  (b_issue_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs change here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_wr_en    = 1'b0;
    a_issue_en = 1'b0;
    a_flush    = 1'b0;
  endtask

  task automatic b_idle();
    b_wr_en    = 1'b0;
    b_issue_en = 1'b0;
    b_flush    = 1'b0;
  endtask

  initial begin
    a_rst_n = 1'b0; a_rd_addr = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    a_issue_en = 1'b0; a_issue_addr = '0; a_flush = 1'b0;
    b_rst_n = 1'b0; b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_issue_en = 1'b0; b_issue_addr = '0; b_flush = 1'b0;

    // Reset for one edge, then every address reads zero and idle.
    tick();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    #1;
    chk("rst_issue_err", {31'd0, a_issue_err}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      a_rd_addr = {3'(7 - a), 3'(a)};
      #0.5;
      chk("rst_data0", {16'd0, a_rd_data[15:0]}, 32'h0000);
      chk("rst_data1", {16'd0, a_rd_data[31:16]}, 32'h0000);
      chk("rst_busy", {30'd0, a_rd_busy}, 32'd0);
    end

    // Same-cycle bypass, then the value from the array.
    tick();
    a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 16'hBEEF;
    a_rd_addr = {3'd4, 3'd5};
    #1;
    chk("bypass_data0", {16'd0, a_rd_data[15:0]}, 32'hBEEF);
    chk("bypass_other_port", {16'd0, a_rd_data[31:16]}, 32'h0000);
    tick();
    a_idle();
    #1;
    chk("mem_data0", {16'd0, a_rd_data[15:0]}, 32'hBEEF);

    // Scoreboard: issue reg 3, busy for two cycles, writeback clears it.
    a_issue_en = 1'b1; a_issue_addr = 3'd3;
    a_rd_addr = {3'd3, 3'd3};
    #1;
    chk("busy_before_issue_edge", {30'd0, a_rd_busy}, 32'd0);
    tick();
    a_idle();
    #1;
    chk("busy_cycle2", {30'd0, a_rd_busy}, 32'd3);
    tick();
    chk("busy_cycle3", {30'd0, a_rd_busy}, 32'd3);
    tick();
    a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 16'h1234;
    #1;
    chk("wb_busy_drop", {30'd0, a_rd_busy}, 32'd0);
    chk("wb_bypass_data", {16'd0, a_rd_data[15:0]}, 32'h1234);
    chk("dual_port_same", {16'd0, a_rd_data[31:16]}, 32'h1234);
    tick();
    a_idle();
    #1;
    chk("wb_pending_clear", {30'd0, a_rd_busy}, 32'd0);
    chk("wb_mem_data", {16'd0, a_rd_data[15:0]}, 32'h1234);

    // Issue and writeback to pending reg 2 together: still pending, no error.
    a_issue_en = 1'b1; a_issue_addr = 3'd2;
    a_rd_addr = {3'd5, 3'd2};
    tick();
    a_wr_en = 1'b1; a_wr_addr = 3'd2; a_wr_data = 16'h2222;
    #1;
    chk("iss_wb_busy_comb", {31'd0, a_rd_busy[0]}, 32'd0);
    tick();
    a_idle();
    #1;
    chk("iss_wb_pending", {31'd0, a_rd_busy[0]}, 32'd1);
    chk("iss_wb_no_err", {31'd0, a_issue_err}, 32'd0);
    chk("iss_wb_data", {16'd0, a_rd_data[15:0]}, 32'h2222);

    // Second issue to reg 2 with no writeback: one-cycle error pulse.
    a_issue_en = 1'b1; a_issue_addr = 3'd2;
    tick();
    a_idle();
    #1;
    chk("double_issue_err", {31'd0, a_issue_err}, 32'd1);
    chk("double_issue_busy", {31'd0, a_rd_busy[0]}, 32'd1);
    tick();
    chk("err_one_cycle", {31'd0, a_issue_err}, 32'd0);

    // Flush with a coincident issue to reg 7 clears everything.
    a_issue_en = 1'b1; a_issue_addr = 3'd1;
    tick();
    a_issue_addr = 3'd4;
    tick();
    a_issue_addr = 3'd6;
    tick();
    a_idle();
    a_rd_addr = {3'd4, 3'd1};
    #1;
    chk("pre_flush_busy", {30'd0, a_rd_busy}, 32'd3);
    a_flush = 1'b1; a_issue_en = 1'b1; a_issue_addr = 3'd7;
    tick();
    a_idle();
    for (int a = 0; a < 8; a++) begin
      a_rd_addr = {3'd7, 3'(a)};
      #0.5;
      chk("flush_busy", {30'd0, a_rd_busy}, 32'd0);
    end
    chk("flush_keeps_data", {16'd0, a_rd_data[15:0]}, 32'h0000);
    a_rd_addr = {3'd2, 3'd5};
    #0.5;
    chk("flush_data5", {16'd0, a_rd_data[15:0]}, 32'hBEEF);
    chk("flush_data2", {16'd0, a_rd_data[31:16]}, 32'h2222);

    // Reset overrides a coincident write and issue.
    a_issue_en = 1'b1; a_issue_addr = 3'd5;
    tick();
    a_idle();
    a_rst_n = 1'b0;
    a_wr_en = 1'b1; a_wr_addr = 3'd6; a_wr_data = 16'h6666;
    a_issue_en = 1'b1; a_issue_addr = 3'd5;
    tick();
    a_rst_n = 1'b1;
    a_idle();
    a_rd_addr = {3'd6, 3'd5};
    #1;
    chk("rst_mid_data5", {16'd0, a_rd_data[15:0]}, 32'h0000);
    chk("rst_mid_data6", {16'd0, a_rd_data[31:16]}, 32'h0000);
    chk("rst_mid_busy", {30'd0, a_rd_busy}, 32'd0);
    chk("rst_mid_err", {31'd0, a_issue_err}, 32'd0);

    // Zero register: writes and issues to reg 0 never show.
    b_wr_en = 1'b1; b_wr_addr = 3'd0; b_wr_data = 32'hFFFF_FFFF;
    b_issue_en = 1'b1; b_issue_addr = 3'd0;
    b_rd_addr = {3'd0, 3'd0, 3'd0};
    #1;
    chk("z_data0_pre", b_rd_data[31:0], 32'h0);
    chk("z_data1_pre", b_rd_data[63:32], 32'h0);
    chk("z_data2_pre", b_rd_data[95:64], 32'h0);
    chk("z_busy_pre", {29'd0, b_rd_busy}, 32'd0);
    tick();
    b_idle();
    #1;
    chk("z_data0_post", b_rd_data[31:0], 32'h0);
    chk("z_data2_post", b_rd_data[95:64], 32'h0);
    chk("z_busy_post", {29'd0, b_rd_busy}, 32'd0);
    b_issue_en = 1'b1; b_issue_addr = 3'd0;
    tick();
    b_idle();
    #1;
    chk("z_no_err", {31'd0, b_issue_err}, 32'd0);
    chk("z_busy_reissue", {29'd0, b_rd_busy}, 32'd0);

    // Nonzero registers in the zero-register build still behave normally.
    b_wr_en = 1'b1; b_wr_addr = 3'd1; b_wr_data = 32'hA5A5_5A5A;
    b_rd_addr = {3'd0, 3'd1, 3'd7};
    #1;
    chk("z_bypass_r1", b_rd_data[63:32], 32'hA5A5_5A5A);
    chk("z_r7_zero", b_rd_data[31:0], 32'h0);
    tick();
    b_idle();
    b_issue_en = 1'b1; b_issue_addr = 3'd1;
    #1;
    chk("z_mem_r1", b_rd_data[63:32], 32'hA5A5_5A5A);
    tick();
    b_idle();
    #1;
    chk("z_busy_r1", {29'd0, b_rd_busy}, 32'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
